// File: rtl/lenet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lenet_pkg
// Description : Shared definitions for the LeNet layer sequencer: scheduler
//               state encoding, layer index constants and default timing.
// Revision    : 1.0 - initial release
// ============================================================================
package lenet_pkg;

    // Scheduler states, 3-bit explicit encoding.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ARM   = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_ERROR = 3'd5
    } sched_state_t;

    // Layer engine indices in execution order.
    localparam int L_CONV1 = 0;
    localparam int L_POOL1 = 1;
    localparam int L_CONV2 = 2;
    localparam int L_POOL2 = 3;
    localparam int L_FC    = 4;

    // Default sequencing timing.
    localparam int c_rst_cyc_def   = 2;
    localparam int c_drain_cyc_def = 8;
    localparam int c_cnt_w_def     = 20;

endpackage
`default_nettype wire

// File: rtl/sched_edge_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sched_edge_cnt
// Description : Rising-edge detector on the selected layer finish bit plus a
//               saturating RUN-cycle counter with a timeout flag.
// Ports       : clk, rst      - clock / asynchronous active-high reset
//               i_fin         - finish bit of the current layer
//               i_arm         - high in ARM; preloads the counter to 1
//               i_run         - high in RUN; advances the counter
//               o_edge        - finish rose this cycle (1 now, 0 last cycle)
//               o_cnt         - current RUN-cycle count
//               o_timeout     - counter at all-ones while running
// Revision    : 1.0 - initial release
// ============================================================================
module sched_edge_cnt #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_fin,
    input  logic             i_arm,
    input  logic             i_run,
    output logic             o_edge,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_timeout
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic             r_fin_d;
    logic [CNT_W-1:0] r_cnt;

    // Loading 1 during ARM makes the count read 1 in the first RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fin_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_fin_d <= i_fin;
            if (i_arm) begin
                r_cnt <= CNT_W'(1);
            end else if (i_run && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_edge    = i_fin & ~r_fin_d;
    assign o_cnt     = r_cnt;
    assign o_timeout = i_run & (r_cnt == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/lenet_layer_sched.sv
`default_nettype none
// ============================================================================
// Module      : lenet_layer_sched
// Description : Top-level LeNet sequencer. Clears, arms, runs and drains each
//               layer engine in index order, owns the ping-pong feature-map
//               bank and weight-BRAM selects, and profiles RUN cycle counts.
// Ports       : clk, rst           - clock / asynchronous active-high reset
//               start, abort       - inference start pulse / synchronous abort
//               layer_finish       - per-layer sticky finish levels
//               layer_en/layer_rst - one-hot enable / clear of current layer
//               cur_layer          - active layer index
//               fm_bank_sel        - ping-pong bank read by current layer
//               w_bram_sel         - one-hot weight BRAM owner
//               busy, done, err    - status / completion pulse / timeout flag
//               layer_cycles(_vld) - RUN length of last finished layer
// Revision    : 1.0 - initial release
// ============================================================================
module lenet_layer_sched
    import lenet_pkg::*;
#(
    parameter int N_LAYERS  = L_FC + 1,
    parameter int RST_CYC   = c_rst_cyc_def,
    parameter int DRAIN_CYC = c_drain_cyc_def,
    parameter int CNT_W     = c_cnt_w_def
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [N_LAYERS-1:0] layer_finish,
    output logic [N_LAYERS-1:0] layer_en,
    output logic [N_LAYERS-1:0] layer_rst,
    output logic [2:0]          cur_layer,
    output logic                fm_bank_sel,
    output logic [N_LAYERS-1:0] w_bram_sel,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    layer_cycles,
    output logic                layer_cycles_vld,
    output logic                err
);

    sched_state_t        r_state, w_state;
    logic [2:0]          r_cur, w_cur;
    logic                r_bank, w_bank;
    logic                r_err, w_err;
    logic                r_done, w_done;
    logic                r_vld, w_vld;
    logic [CNT_W-1:0]    r_lc, w_lc;
    logic [7:0]          r_tmr, w_tmr;

    logic [N_LAYERS-1:0] w_onehot;
    logic                w_fin_sel;
    logic                w_edge;
    logic                w_timeout;
    logic [CNT_W-1:0]    w_cnt;

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            w_onehot[i] = (r_cur == 3'(i));
        end
    end

    // Finish bits of non-current layers are masked off here.
    assign w_fin_sel = |(layer_finish & w_onehot);

    sched_edge_cnt #(
        .CNT_W (CNT_W)
    ) u_edge_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_fin     (w_fin_sel),
        .i_arm     (r_state == S_ARM),
        .i_run     (r_state == S_RUN),
        .o_edge    (w_edge),
        .o_cnt     (w_cnt),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_bank  <= 1'b0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_vld   <= 1'b0;
            r_lc    <= '0;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state;
            r_cur   <= w_cur;
            r_bank  <= w_bank;
            r_err   <= w_err;
            r_done  <= w_done;
            r_vld   <= w_vld;
            r_lc    <= w_lc;
            r_tmr   <= w_tmr;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cur   = r_cur;
        w_bank  = r_bank;
        w_err   = r_err;
        w_done  = 1'b0;
        w_vld   = 1'b0;
        w_lc    = r_lc;
        w_tmr   = r_tmr;
        if (abort) begin
            // Abort outranks start and skips the drain; err is left alone.
            w_state = S_IDLE;
            w_tmr   = '0;
        end else begin
            case (r_state)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        w_state = S_CLR;
                        w_cur   = '0;
                        w_bank  = 1'b0;
                        w_err   = 1'b0;
                        w_tmr   = '0;
                    end
                end
                S_CLR: begin
                    if (r_tmr == 8'(RST_CYC - 1)) begin
                        w_state = S_ARM;
                        w_tmr   = '0;
                    end else begin
                        w_tmr = r_tmr + 8'd1;
                    end
                end
                S_ARM: begin
                    // A finish still high after the clear means the clear failed.
                    if (w_fin_sel) begin
                        w_state = S_ERROR;
                        w_err   = 1'b1;
                    end else begin
                        w_state = S_RUN;
                    end
                end
                S_RUN: begin
                    // Finish is tested first so it wins over a same-cycle timeout.
                    if (w_edge) begin
                        w_state = S_DRAIN;
                        w_lc    = w_cnt;
                        w_vld   = 1'b1;
                        w_tmr   = '0;
                    end else if (w_timeout) begin
                        w_state = S_ERROR;
                        w_err   = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_tmr == 8'(DRAIN_CYC - 1)) begin
                        w_tmr = '0;
                        if (r_cur == 3'(N_LAYERS - 1)) begin
                            w_state = S_IDLE;
                            w_done  = 1'b1;
                        end else begin
                            w_state = S_CLR;
                            w_cur   = r_cur + 3'd1;
                            w_bank  = ~r_bank;
                        end
                    end else begin
                        w_tmr = r_tmr + 8'd1;
                    end
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    assign layer_en         = (r_state == S_RUN) ? w_onehot : '0;
    assign w_bram_sel       = (r_state == S_RUN) ? w_onehot : '0;
    assign layer_rst        = (r_state == S_CLR) ? w_onehot : '0;
    assign busy             = (r_state != S_IDLE) && (r_state != S_ERROR);
    assign cur_layer        = r_cur;
    assign fm_bank_sel      = r_bank;
    assign done             = r_done;
    assign layer_cycles     = r_lc;
    assign layer_cycles_vld = r_vld;
    assign err              = r_err;

endmodule
`default_nettype wire
